// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between load/store and instruction fetch, with 1-cycle read response routing.
// Build option: MEM_ARB_FAIRNESS_EN enables the fetch starvation override (streak counter).
module mem_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [XLEN-1:0] ls_rdata,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  logic resp_pend_q, resp_pend_d;
  logic resp_owner_q, resp_owner_d;
  logic fetch_wins;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] streak_q, streak_d;

  assign fetch_wins = (streak_q == LIMIT);

  always_comb begin
    streak_d = streak_q;
    if (if_gnt || !if_req) begin
      streak_d = '0;
    end else if (ls_gnt) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign fetch_wins = 1'b0;
`endif

  // Grants are masked by reset so nothing reaches the RAM while rst is low.
  always_comb begin
    ls_gnt = rst & ls_req & ~(if_req & fetch_wins);
    if_gnt = rst & if_req & (~ls_req | fetch_wins);
  end

  always_comb begin
    mem_en    = ls_gnt | if_gnt;
    mem_we    = ls_gnt & ls_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ls_gnt) begin
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  always_comb begin
    resp_pend_d  = mem_en & ~mem_we;
    resp_owner_d = resp_owner_q;
    if (if_gnt) begin
      resp_owner_d = 1'b1;
    end else if (ls_gnt && !ls_we) begin
      resp_owner_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_pend_q  <= 1'b0;
      resp_owner_q <= 1'b0;
    end else begin
      resp_pend_q  <= resp_pend_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  always_comb begin
    ls_rvalid = resp_pend_q & ~resp_owner_q;
    if_rvalid = resp_pend_q &  resp_owner_q;
    ls_rdata  = ls_rvalid ? mem_rdata : '0;
    if_rdata  = if_rvalid ? mem_rdata : '0;
  end

endmodule
